// File: rtl/freq_counter_mc.sv
// rtl/freq_counter_mc.sv - multi-channel gate-width / period counter in the clk_samp domain (optional FREQ_CNT_SAT_EN: saturating counters)
module freq_counter_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic                     clk_samp,
    input  logic                     sys_if_rstn,
    input  logic [NUM_CH-1:0]        en_sample,
    output logic [NUM_CH*CNT_W-1:0]  clk_count,
    output logic [NUM_CH-1:0]        count_valid,
    output logic [NUM_CH-1:0]        count_ovf
);

    localparam bit              PERIOD_MODE = (MODE != 0);
    localparam logic [CNT_W-1:0] CNT_ONES   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Synchroniser chains and delayed copy of each synchronised input
    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
    logic [NUM_CH-1:0]      dly_q, dly_d;

    // Registered edge pulses
    logic [NUM_CH-1:0]      start_q, start_d;
    logic [NUM_CH-1:0]      end_q, end_d;

    // Fills with ones after reset; edge detection stays masked until the
    // synchroniser and delay flop both hold post-reset samples, so an input
    // already high at reset release is not mistaken for a rising edge.
    logic [SYNC_STAGES:0]   prime_q, prime_d;

    // Running counters and their overflow history
    logic [CNT_W-1:0]       cnt_q [NUM_CH];
    logic [CNT_W-1:0]       cnt_d [NUM_CH];
    logic [NUM_CH-1:0]      ovf_q, ovf_d;
    logic [NUM_CH-1:0]      armed_q, armed_d;

    // Published results
    logic [CNT_W-1:0]       res_q [NUM_CH];
    logic [CNT_W-1:0]       res_d [NUM_CH];
    logic [NUM_CH-1:0]      valid_q, valid_d;
    logic [NUM_CH-1:0]      ovf_out_q, ovf_out_d;

    // Synchronise inputs and detect rising/falling edges of the synchronised level
    always_comb begin
        prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
        dly_d   = '0;
        start_d = '0;
        end_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], en_sample[i]};
            dly_d[i]   = sync_q[i][SYNC_STAGES-1];
            start_d[i] = prime_q[SYNC_STAGES] &  sync_q[i][SYNC_STAGES-1] & ~dly_q[i];
            end_d[i]   = prime_q[SYNC_STAGES] & ~sync_q[i][SYNC_STAGES-1] &  dly_q[i];
        end
    end

    // Running counter: restart at 1 on start, otherwise count up and flag overflow
    always_comb begin
        ovf_d   = ovf_q;
        armed_d = armed_q | start_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (start_q[i]) begin
                cnt_d[i] = CNT_ONE;
                ovf_d[i] = 1'b0;
            end else begin
                if (cnt_q[i] == CNT_ONES) begin
                    ovf_d[i] = 1'b1;
                end
`ifdef FREQ_CNT_SAT_EN
                if (cnt_q[i] != CNT_ONES) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
`else
                cnt_d[i] = cnt_q[i] + CNT_ONE;
`endif
            end
        end
    end

    // Publish the pre-update count on end (gate mode) or start (period mode) once armed
    always_comb begin
        valid_d   = '0;
        ovf_out_d = ovf_out_q;
        for (int i = 0; i < NUM_CH; i++) begin
            res_d[i] = res_q[i];
            if ((PERIOD_MODE ? start_q[i] : end_q[i]) && armed_q[i]) begin
                res_d[i]     = cnt_q[i];
                ovf_out_d[i] = ovf_q[i];
                valid_d[i]   = 1'b1;
            end
        end
    end

    // State registers, all cleared asynchronously by sys_if_rstn
    always_ff @(posedge clk_samp or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            prime_q   <= '0;
            dly_q     <= '0;
            start_q   <= '0;
            end_q     <= '0;
            ovf_q     <= '0;
            armed_q   <= '0;
            valid_q   <= '0;
            ovf_out_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            prime_q   <= prime_d;
            dly_q     <= dly_d;
            start_q   <= start_d;
            end_q     <= end_d;
            ovf_q     <= ovf_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            ovf_out_q <= ovf_out_d;
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
                res_q[i]  <= res_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign clk_count[g*CNT_W +: CNT_W] = res_q[g];
    end

    assign count_valid = valid_q;
    assign count_ovf   = ovf_out_q;

endmodule

// File: tb/tb_freq_counter_mc.sv
// tb/tb_freq_counter_mc.sv - scoreboard bench for freq_counter_mc (gate, period and 8-bit overflow instances)
module tb_freq_counter_mc;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   en_g = '0;
    logic [3:0]   en_p = '0;
    logic [0:0]   en_s = '0;
    logic [127:0] cnt_g, cnt_p;
    logic [7:0]   cnt_s;
    logic [3:0]   vld_g, vld_p, ovf_g, ovf_p;
    logic [0:0]   vld_s, ovf_s;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int     dut;
        int     ch;
        longint lo;
        longint hi;
        bit     ovf;
        int     at;
    } exp_t;

    exp_t sbq[$];

    freq_counter_mc #(.NUM_CH(4), .CNT_W(32), .SYNC_STAGES(2), .MODE(0)) dut_g (
        .clk_samp(clk), .sys_if_rstn(rstn), .en_sample(en_g),
        .clk_count(cnt_g), .count_valid(vld_g), .count_ovf(ovf_g));

    freq_counter_mc #(.NUM_CH(4), .CNT_W(32), .SYNC_STAGES(2), .MODE(1)) dut_p (
        .clk_samp(clk), .sys_if_rstn(rstn), .en_sample(en_p),
        .clk_count(cnt_p), .count_valid(vld_p), .count_ovf(ovf_p));

    freq_counter_mc #(.NUM_CH(1), .CNT_W(8), .SYNC_STAGES(2), .MODE(0)) dut_s (
        .clk_samp(clk), .sys_if_rstn(rstn), .en_sample(en_s),
        .clk_count(cnt_s), .count_valid(vld_s), .count_ovf(ovf_s));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe on any instance pops one expectation and is checked against it
    always @(negedge clk) begin
        logic   v;
        logic   o;
        longint val;
        exp_t   e;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                v = 1'b0; o = 1'b0; val = 0;
                if (d == 0) begin
                    v = vld_g[c]; o = ovf_g[c]; val = longint'(cnt_g[c*32 +: 32]);
                end else if (d == 1) begin
                    v = vld_p[c]; o = ovf_p[c]; val = longint'(cnt_p[c*32 +: 32]);
                end else if (c == 0) begin
                    v = vld_s[0]; o = ovf_s[0]; val = longint'(cnt_s);
                end
                if (v) begin
                    vectors++;
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_strobe: dut%0d ch%0d val=%0d ovf=%0d cyc=%0d, required no strobe",
                                 d, c, val, o, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (e.dut !== d || e.ch !== c || val < e.lo || val > e.hi || o !== e.ovf ||
                            (e.at >= 0 && cyc !== e.at)) begin
                            miscompares++;
                            $display("FAIL strobe: got dut%0d ch%0d val=%0d ovf=%0d cyc=%0d, required dut%0d ch%0d val=%0d..%0d ovf=%0d cyc=%0d",
                                     d, c, val, o, cyc, e.dut, e.ch, e.lo, e.hi, e.ovf, e.at);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int d, input int c, input longint lo, input longint hi,
                        input bit o, input int at);
        exp_t e;
        e.dut = d; e.ch = c; e.lo = lo; e.hi = hi; e.ovf = o; e.at = at;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d strobes still pending after %0d cycles, required 0", sbq.size(), budget);
            sbq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cnt_g, cnt_p, cnt_s} !== '0) begin
            miscompares++;
            $display("FAIL reset_count: got %h, required 0", {cnt_g, cnt_p, cnt_s});
        end
        vectors++;
        if ({vld_g, vld_p, vld_s, ovf_g, ovf_p, ovf_s} !== '0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 0", {vld_g, vld_p, vld_s, ovf_g, ovf_p, ovf_s});
        end
        rstn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_gate();
        en_g[0] = 1'b1;
        repeat (1000) @(negedge clk);
        en_g[0] = 1'b0;
        push(0, 0, 1000, 1000, 1'b0, cyc + 4);
        wait_drain(20);
        vectors++;
        if (cnt_g[127:32] !== '0) begin
            miscompares++;
            $display("FAIL gate_other_slices: got %h, required 0", cnt_g[127:32]);
        end
    endtask

    task automatic test_period();
        for (int p = 0; p < 5; p++) begin
            en_p[2] = 1'b1;
            if (p > 0) push(1, 2, 37, 37, 1'b0, cyc + 4);
            repeat (18) @(negedge clk);
            en_p[2] = 1'b0;
            repeat (19) @(negedge clk);
        end
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 4; c++) begin
                if (t == 40 - 10 * (c + 1)) en_g[c] = 1'b1;
            end
            @(negedge clk);
        end
        en_g = '0;
        for (int c = 0; c < 4; c++) push(0, c, 10 * (c + 1), 10 * (c + 1), 1'b0, cyc + 4);
        wait_drain(20);
    endtask

    task automatic test_overflow();
        longint exp_big;
`ifdef FREQ_CNT_SAT_EN
        exp_big = 255;
`else
        exp_big = 44;
`endif
        en_s[0] = 1'b1;
        repeat (300) @(negedge clk);
        en_s[0] = 1'b0;
        push(2, 0, exp_big, exp_big, 1'b1, cyc + 4);
        wait_drain(20);
        en_s[0] = 1'b1;
        repeat (50) @(negedge clk);
        en_s[0] = 1'b0;
        push(2, 0, 50, 50, 1'b0, cyc + 4);
        wait_drain(20);
    endtask

    task automatic test_reset_mid_gate();
        en_g[0] = 1'b1;
        repeat (100) @(negedge clk);
        rstn = 1'b0;
        #1;
        vectors++;
        if ({cnt_g, cnt_p, cnt_s} !== '0) begin
            miscompares++;
            $display("FAIL midreset_count: got %h, required 0", {cnt_g, cnt_p, cnt_s});
        end
        vectors++;
        if ({vld_g, vld_p, vld_s, ovf_g, ovf_p, ovf_s} !== '0) begin
            miscompares++;
            $display("FAIL midreset_flags: got %b, required 0", {vld_g, vld_p, vld_s, ovf_g, ovf_p, ovf_s});
        end
        repeat (100) @(negedge clk);
        rstn = 1'b1;
        repeat (300) @(negedge clk);
        en_g[0] = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (cnt_g[31:0] !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_trailing_fall: got %0d, required 0", cnt_g[31:0]);
        end
        en_g[0] = 1'b1;
        repeat (80) @(negedge clk);
        en_g[0] = 1'b0;
        push(0, 0, 80, 80, 1'b0, cyc + 4);
        wait_drain(20);
    endtask

    task automatic test_random_phase();
        int ph;
        int dl;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            ph = int'($urandom_range(2, 8));
            dl = int'($urandom_range(0, 2)) - 1;
            #(ph);
            en_g[1] = 1'b1;
            #(10000 + dl);
            en_g[1] = 1'b0;
            push(0, 1, 999, 1001, 1'b0, -1);
            wait_drain(20);
        end
        vectors++;
        if ($isunknown({cnt_g, cnt_p, cnt_s, vld_g, vld_p, vld_s, ovf_g, ovf_p, ovf_s})) begin
            miscompares++;
            $display("FAIL no_x: got %h, required no X/Z", {cnt_g, vld_g, ovf_g});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_gate();
        test_period();
        test_back_to_back();
        test_overflow();
        test_reset_mid_gate();
        test_random_phase();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
